dcache_wb_dm: RTL
=================

# dcache_wb_dm

Direct-mapped, write-back, write-allocate data cache that serves the processor-side data-cache port of the pipelined RISC-V core: read/write requests with word addresses in, read data and a stall flag out. It sits between the core's D-cache interface and a block-wide main-memory port. On a miss it writes back any dirty victim, then refills the block, holding the core in stall for the whole sequence.

## Interface
- BLOCKS, default 8: number of cache lines; power of two, at least 2. IDX = log2(BLOCKS).
- Line size is fixed at 4 words (128 bits).
- clk, input, 1: sole clock, rising edge.
- rst, input, 1: reset, synchronous, active-high. One clock; reset is synchronous and active-high.
- proc_read, input, 1: read request.
- proc_write, input, 1: write request. Takes priority over proc_read if both are high.
- proc_addr, input, 30: word address. [1:0] is the word offset, [IDX+1:2] the index, [29:IDX+2] the tag.
- proc_wdata, input, 32: write data, stored verbatim with no byte reordering.
- proc_stall, output, 1: request not yet complete; combinational.
- proc_rdata, output, 32: read data; combinational, valid when proc_read=1 and proc_stall=0.
- mem_read, output, 1: block read request; registered.
- mem_write, output, 1: block write request; registered.
- mem_addr, output, 28: block address, equal to {tag,index}; registered.
- mem_wdata, output, 128: victim block, word 0 in bits [31:0]; registered.
- mem_ready, input, 1: one-cycle completion pulse from memory.
- mem_rdata, input, 128: refill block; valid when mem_ready=1.

## Operation
- Per line state: valid bit, dirty bit, tag, and 4×32 data.
- States:
  - COMPARE (reset state).
  - WRITEBACK.
  - ALLOCATE.
- COMPARE:
  - hit = valid[idx] & (tag[idx] == addr tag).
  - No request: proc_stall=0. No state change.
  - Read hit: proc_stall=0, proc_rdata = data[idx][offset].
  - Write hit: proc_stall=0. On the clock edge, write the word and set dirty=1.
  - Miss with a victim that is invalid or clean: proc_stall=1. Next state ALLOCATE. Register mem_read=1 and mem_addr=proc_addr[29:2].
  - Miss with a valid, dirty victim: proc_stall=1. Next state WRITEBACK. Register mem_write=1, mem_addr={old tag,idx} and mem_wdata=data[idx].
- WRITEBACK:
  - proc_stall=1. Outputs are held until mem_ready=1.
  - On mem_ready: mem_write=0, dirty[idx]=0, mem_read=1, mem_addr=proc_addr[29:2], next state ALLOCATE.
- ALLOCATE:
  - proc_stall=1. Outputs are held until mem_ready=1.
  - On mem_ready: data[idx]=mem_rdata, tag updated, valid=1, dirty=0, mem_read=0, next state COMPARE.
  - The original request is then re-evaluated as a hit. A write therefore completes through the normal hit path and sets dirty.
- mem_read and mem_write are never high together.
- The core holds proc_read, proc_write, proc_addr and proc_wdata stable while proc_stall=1. The cache relies on this and does not latch the request.
- Reset (rst=1 at an edge), from any state:
  - State returns to COMPARE.
  - All valid and dirty bits clear. Tags and data are don't-care.
  - mem_read=0, mem_write=0, mem_addr=0, mem_wdata=0.
  - Any in-flight memory transaction is abandoned. A mem_ready arriving after reset is ignored.

## Timing
- Hit: zero added latency. proc_stall is low in the same cycle as the request; the write commits at the next edge.
- Clean miss detected at cycle n:
  - mem_read is high from n+1.
  - If mem_ready is sampled at cycle m, mem_read is low at m+1 and state is COMPARE at m+1.
  - proc_stall=0 at m+1 (hit).
  - Total stall is m−n+1 cycles.
- Dirty miss: the WRITEBACK phase is added first. mem_read rises in the cycle after the write's mem_ready is sampled.
- mem_ready sampled high in COMPARE is ignored.
- Outputs immediately after reset: proc_stall = (proc_read|proc_write), since every access misses; all mem_* outputs are 0.

## Test plan
- Cold read miss:
  - Stimulus: reset, then proc_read with proc_addr=0x00000001.
  - Response: proc_stall=1 and mem_read=1 with mem_addr=0 next cycle. Return mem_ready plus mem_rdata=128'h44444444_33333333_22222222_11111111 after 3 cycles.
  - Response: the next cycle has proc_stall=0 and proc_rdata=32'h22222222.
- Write hit and readback:
  - Stimulus: after the above, write 0xDEADBEEF to addr 0x00000002, then read it back.
  - Response: both accesses have proc_stall=0 with no mem_* activity; the read returns 0xDEADBEEF.
- Dirty eviction (BLOCKS=8):
  - Stimulus: read addr 0x00000020, which maps to index 0 with a different tag.
  - Response: mem_write=1, mem_addr=0, mem_wdata=128'h44444444_DEADBEEF_22222222_11111111.
  - Response: after mem_ready, mem_read=1 with mem_addr=0x8; after the refill, the read hits.
- Write miss on a clean line:
  - Stimulus: write 0x12345678 to addr 0x00000045.
  - Response: ALLOCATE only, with mem_addr=0x11. After the refill, the word is stored and the line is dirty.
  - Check: a later conflicting miss writes this block back.
- Reset mid-ALLOCATE:
  - Stimulus: assert rst while mem_read=1.
  - Response: next cycle mem_read=0 and mem_addr=0. A late mem_ready is ignored. A subsequent read to any address misses.
- Idle and both-high:
  - Stimulus: proc_read=proc_write=0.
  - Response: proc_stall=0 and no state change.
  - Stimulus: proc_read=proc_write=1 on a hit.
  - Response: treated as a write, with dirty set.

Source files
------------

// File: rtl/dcache_wb_dm.sv
// Direct-mapped, write-back, write-allocate data cache with 4-word lines.
// It sits between the core's data port and a block-wide main-memory port.
module dcache_wb_dm #(
    parameter int BLOCKS = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         proc_read,
    input  logic         proc_write,
    input  logic [29:0]  proc_addr,
    input  logic [31:0]  proc_wdata,
    output logic         proc_stall,
    output logic [31:0]  proc_rdata,
    output logic         mem_read,
    output logic         mem_write,
    output logic [27:0]  mem_addr,
    output logic [127:0] mem_wdata,
    input  logic         mem_ready,
    input  logic [127:0] mem_rdata
);
    localparam int IDX  = $clog2(BLOCKS);
    localparam int TAGW = 28 - IDX;

    typedef enum logic [1:0] {
        COMPARE,
        WRITEBACK,
        ALLOCATE
    } state_t;

    state_t            r_state;
    logic [BLOCKS-1:0] r_valid;
    logic [BLOCKS-1:0] r_dirty;
    logic [TAGW-1:0]   r_tag  [BLOCKS];
    logic [127:0]      r_data [BLOCKS];
    logic              r_memRead;
    logic              r_memWrite;
    logic [27:0]       r_memAddr;
    logic [127:0]      r_memWdata;

    logic [IDX-1:0]    w_idx;
    logic [TAGW-1:0]   w_tag;
    logic [1:0]        w_off;
    logic              w_req;
    logic              w_hit;
    logic              w_writeHit;
    logic              w_refill;

    assign w_idx      = proc_addr[IDX+1:2];
    assign w_tag      = proc_addr[29:IDX+2];
    assign w_off      = proc_addr[1:0];
    assign w_req      = proc_read | proc_write;
    assign w_hit      = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
    assign w_writeHit = (r_state == COMPARE) && proc_write && w_hit;
    assign w_refill   = (r_state == ALLOCATE) && mem_ready;

    // The request is only complete when it hits while the FSM is idle.
    assign proc_stall = (r_state != COMPARE) || (w_req && !w_hit);
    assign proc_rdata = r_data[w_idx][{w_off, 5'b0} +: 32];

    assign mem_read   = r_memRead;
    assign mem_write  = r_memWrite;
    assign mem_addr   = r_memAddr;
    assign mem_wdata  = r_memWdata;

    // Tag and data arrays need no reset: valid bits gate every use of them.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (w_refill) begin
                r_data[w_idx] <= mem_rdata;
                r_tag[w_idx]  <= w_tag;
            end else if (w_writeHit) begin
                r_data[w_idx][{w_off, 5'b0} +: 32] <= proc_wdata;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= COMPARE;
            r_valid    <= '0;
            r_dirty    <= '0;
            r_memRead  <= 1'b0;
            r_memWrite <= 1'b0;
            r_memAddr  <= '0;
            r_memWdata <= '0;
        end else begin
            case (r_state)
                COMPARE: begin
                    if (w_req && w_hit) begin
                        if (proc_write) begin
                            r_dirty[w_idx] <= 1'b1;
                        end
                    end else if (w_req) begin
                        if (r_valid[w_idx] && r_dirty[w_idx]) begin
                            r_memWrite <= 1'b1;
                            r_memAddr  <= {r_tag[w_idx], w_idx};
                            r_memWdata <= r_data[w_idx];
                            r_state    <= WRITEBACK;
                        end else begin
                            r_memRead  <= 1'b1;
                            r_memAddr  <= proc_addr[29:2];
                            r_state    <= ALLOCATE;
                        end
                    end
                end
                WRITEBACK: begin
                    if (mem_ready) begin
                        r_memWrite     <= 1'b0;
                        r_dirty[w_idx] <= 1'b0;
                        r_memRead      <= 1'b1;
                        r_memAddr      <= proc_addr[29:2];
                        r_state        <= ALLOCATE;
                    end
                end
                ALLOCATE: begin
                    // The held request replays as a hit next cycle; a write sets dirty then.
                    if (mem_ready) begin
                        r_valid[w_idx] <= 1'b1;
                        r_dirty[w_idx] <= 1'b0;
                        r_memRead      <= 1'b0;
                        r_state        <= COMPARE;
                    end
                end
                default: begin
                    r_state <= COMPARE;
                end
            endcase
        end
    end
endmodule
